// File: rtl/aes_pkg.sv
// Shared AES types, SubBytes FSM encoding, forward S-box table and ShiftRows byte mapping.
// Latency: none; the package holds only types, constants and a pure function.
// Backpressure: not applicable.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sb_state_e;

    // Forward S-box, indexed by the input byte.
    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte i lives at s[127-8i -: 8], i = row + 4*column.
    // Row r is rotated left by r columns: out(r,c) = in(r, (c+r) mod 4).
    function automatic aes_state_t shiftrows_map(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input byte.
// Ports: plain (byte to substitute), subst (S-box image).
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t plain,
    output aes_byte_t subst
);

    assign subst = SBOX[plain];

endmodule

// File: rtl/aes_subbytes_serial.sv
// Serial AES SubBytes: BYTES_PER_CYCLE shared S-boxes substitute a 128-bit state over NUM_STEPS cycles.
// Latency: out_valid rises NUM_STEPS cycles after the accepting edge; one block per NUM_STEPS+2 cycles.
// Backpressure: in_ready low outside IDLE; result held in DONE until out_ready; one bubble after each transfer.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_state upstream handshake;
//        out_valid/out_ready/out_state downstream handshake; busy high while substituting.
// Optional: define AES_SUBBYTES_SHIFTROWS_EN to fold ShiftRows into the DONE output mapping.
module aes_subbytes_serial
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int STEP_W    = $clog2(NUM_STEPS) + 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
        $error("aes_subbytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    sb_state_e   state, state_nxt;
    logic [STEP_W-1:0] step;
    aes_state_t  work;
    logic        accept;
    logic        step_last;

    logic [BYTES_PER_CYCLE-1:0][7:0] sbox_in;
    logic [BYTES_PER_CYCLE-1:0][7:0] sbox_out;

    assign accept    = in_valid && in_ready;
    assign step_last = (step == STEP_W'(NUM_STEPS - 1));

    // Lane k of step s handles byte s*BPC+k; select this step's bytes for the shared S-boxes.
    always_comb begin
        sbox_in = '0;
        for (int s = 0; s < NUM_STEPS; s++) begin
            if (step == STEP_W'(s)) begin
                for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                    sbox_in[k] = work[127 - 8*(s*BYTES_PER_CYCLE + k) -: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
        aes_sbox u_sbox (
            .plain (sbox_in[k]),
            .subst (sbox_out[k])
        );
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (step_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= in_state;
                step <= '0;
            end else if (state == ST_BUSY) begin
                // Counter is wide enough to reach NUM_STEPS and parks there until the next acceptance.
                step <= step + 1'b1;
                for (int j = 0; j < 16; j++) begin
                    if (step == STEP_W'(j / BYTES_PER_CYCLE)) begin
                        work[127 - 8*j -: 8] <= sbox_out[j % BYTES_PER_CYCLE];
                    end
                end
            end
        end
    end

    // Output is zero except in DONE, so partial results never leak downstream.
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    assign out_state = (state == ST_DONE) ? shiftrows_map(work) : '0;
`else
    assign out_state = (state == ST_DONE) ? work : '0;
`endif

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Self-checking bench for aes_subbytes_serial at BYTES_PER_CYCLE = 1, 4 and 16 sharing one input stream.
// Latency: expected 16, 4 and 1 cycles from acceptance to out_valid.
// Backpressure: exercises DONE stall, bubble, and async reset during BUSY and DONE.
module tb_aes_subbytes_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;

    logic [2:0]   rdy;
    logic [2:0]   vld;
    logic [2:0]   bsy;
    logic [127:0] dat [3];

    int checks   = 0;
    int failures = 0;

    localparam int LAT [3] = '{16, 4, 1};

    localparam logic [127:0] KNOWN_IN = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
    localparam logic [127:0] KNOWN_EXP = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
`else
    localparam logic [127:0] KNOWN_EXP = 128'h637c777bf26b6fc53001672bfed7ab76;
`endif
    localparam logic [127:0] ALL00 = 128'h00000000000000000000000000000000;
    localparam logic [127:0] ALLFF = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ALL53 = 128'h53535353535353535353535353535353;
    localparam logic [127:0] ALL63 = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALL16 = 128'h16161616161616161616161616161616;
    localparam logic [127:0] ALLED = 128'hedededededededededededededededed;

    always #5 clk = ~clk;

    aes_subbytes_serial #(.BYTES_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_state(in_state),
        .out_valid(vld[0]), .out_ready(out_ready), .out_state(dat[0]), .busy(bsy[0])
    );
    aes_subbytes_serial #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_state(in_state),
        .out_valid(vld[1]), .out_ready(out_ready), .out_state(dat[1]), .busy(bsy[1])
    );
    aes_subbytes_serial #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_state(in_state),
        .out_valid(vld[2]), .out_ready(out_ready), .out_state(dat[2]), .busy(bsy[2])
    );

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Presents one block to all three instances with out_ready high and checks latency and result.
    task automatic run_block(input string nm, input logic [127:0] din, input logic [127:0] exp);
        int           lat [3];
        logic [127:0] got [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            got[i] = '0;
        end
        @(negedge clk);
        check({nm, " in_ready before"}, 128'(rdy), 128'h7);
        in_valid = 1'b1;
        in_state = din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({nm, " busy after accept"}, 128'(bsy), 128'h7);
        check({nm, " in_ready after accept"}, 128'(rdy), 128'h0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && lat[i] == 0) begin
                    lat[i] = c;
                    got[i] = dat[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s latency bpc_idx%0d", nm, i), 128'(lat[i]), 128'(LAT[i]));
            check($sformatf("%s data bpc_idx%0d", nm, i), got[i], exp);
        end
    endtask

    initial begin
        int lat0;

        vecs[0] = '{name: "known", din: KNOWN_IN, exp: KNOWN_EXP};
        vecs[1] = '{name: "all00", din: ALL00,    exp: ALL63};
        vecs[2] = '{name: "allff", din: ALLFF,    exp: ALL16};
        vecs[3] = '{name: "all53", din: ALL53,    exp: ALLED};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_state  = '0;

        // Reset values before any clock edge.
        #2;
        check("reset in_ready", 128'(rdy), 128'h7);
        check("reset out_valid", 128'(vld), 128'h0);
        check("reset busy", 128'(bsy), 128'h0);
        check("reset out_state", dat[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v].name, vecs[v].din, vecs[v].exp);
        end

        // Backpressure: stall in DONE with a new state waiting upstream.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = KNOWN_IN;
        @(posedge clk);
        #1;
        in_state = ALL53;
        lat0 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (vld[0]) begin
                lat0 = c;
                break;
            end
        end
        check("bp latency", 128'(lat0), 128'd16);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp stall data c%0d", c), dat[0], KNOWN_EXP);
            check($sformatf("bp stall in_ready c%0d", c), 128'(rdy), 128'h0);
            check($sformatf("bp stall out_valid c%0d", c), 128'(vld), 128'h7);
        end
        check("bp stall data bpc16", dat[2], KNOWN_EXP);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp bubble out_valid", 128'(vld), 128'h0);
        check("bp bubble in_ready", 128'(rdy), 128'h7);
        check("bp bubble busy", 128'(bsy), 128'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp second accept busy", 128'(bsy), 128'h7);
        lat0 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (vld[0]) begin
                lat0 = c;
                break;
            end
        end
        check("bp second latency", 128'(lat0), 128'd16);
        check("bp second data", dat[0], ALLED);
        @(posedge clk);
        #1;

        // Async reset at step 7 of a block; only the fresh block may produce output.
        @(negedge clk);
        in_valid = 1'b1;
        in_state = ALLFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("midbusy busy before reset", 128'(bsy[0]), 128'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midbusy reset in_ready", 128'(rdy), 128'h7);
        check("midbusy reset out_valid", 128'(vld), 128'h0);
        check("midbusy reset busy", 128'(bsy), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block("after reset", KNOWN_IN, KNOWN_EXP);

        // Async reset while holding a result in DONE.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = ALL00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat0 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (vld[0]) begin
                lat0 = c;
                break;
            end
        end
        check("middone latency", 128'(lat0), 128'd16);
        check("middone data", dat[0], ALL63);
        #3;
        rst_n = 1'b0;
        #1;
        check("middone reset out_state", dat[0], 128'h0);
        check("middone reset out_valid", 128'(vld), 128'h0);
        check("middone reset in_ready", 128'(rdy), 128'h7);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
